dmem_responder: RTL and testbench

//  Synthesizable memory-side responder for the cpu's imem/dmem handshake. The cpu drives

---
 rtl/dmem_if.sv | 23 ++
 rtl/dmem_responder.sv | 143 ++++++++++++++
 tb/tb_dmem_responder.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/dmem_if.sv
// Bundle of the cpu-side imem/dmem request/response signals between initiator and responder.
interface dmem_if;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic        mem_err;

  // Handshake: the initiator holds read/write (plus address/wmask/wdata) until it sees
  // mem_resp; mem_resp is a one-cycle pulse and mem_rdata is meaningful only in that cycle.
  modport master (
    output mem_address, mem_read, mem_write, mem_wmask, mem_wdata,
    input  mem_rdata, mem_resp, mem_err
  );

  modport slave (
    input  mem_address, mem_read, mem_write, mem_wmask, mem_wdata,
    output mem_rdata, mem_resp, mem_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency memory responder for one cpu imem/dmem port (magic-memory stand-in).
// Optional protocol checker enabled by defining DMEM_RESP_CHECK_EN.
module dmem_responder #(
  parameter int    DEPTH     = 1024,
  parameter int    LATENCY   = 2,
  parameter string INIT_FILE = ""
) (
  input  logic       clk,
  input  logic       rst,
  dmem_if.slave      bus,
  output logic [1:0] dbg_state
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wmask_q, wmask_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;
  logic          resp_q, resp_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [IW-1:0] idx_d;
  logic          do_write;

  logic [31:0] mem [DEPTH];

  assign idx_d = addr_d[IW+1:2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    unique case (state_q)
      IDLE: begin
        if (bus.mem_read | bus.mem_write) begin
          addr_d  = bus.mem_address;
          wdata_d = bus.mem_wdata;
          wmask_d = bus.mem_wmask;
          rd_d    = bus.mem_read;
          wr_d    = bus.mem_write;
          cnt_d   = CW'(LATENCY - 1);
          state_d = (LATENCY == 1) ? RESP : BUSY;
        end
      end
      // cnt reaches zero on the same edge that enters RESP
      BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Outputs are registered: resp/rdata are loaded on the edge that enters RESP.
    resp_d   = (state_d == RESP);
    rdata_d  = (resp_d && rd_d && !wr_d) ? mem[idx_d] : 32'h0;
    do_write = resp_d && wr_d && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      resp_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      resp_q  <= resp_d;
      rdata_q <= rdata_d;
    end
  end

  // Array has no reset; a reset mid-transaction suppresses the pending write via do_write.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask_d[b]) mem[idx_d][8*b +: 8] <= wdata_d[8*b +: 8];
      end
    end
  end

  assign bus.mem_resp  = resp_q;
  assign bus.mem_rdata = rdata_q;
  assign dbg_state     = state_q;

`ifdef DMEM_RESP_CHECK_EN
  logic       err_q, err_d;
  logic       viol;
  logic [3:0] low_mask;

  always_comb begin
    low_mask = (4'b0001 << bus.mem_address[1:0]) - 4'd1;
    viol     = bus.mem_read & bus.mem_write;
    if ((state_q == IDLE) && (bus.mem_read | bus.mem_write) &&
        (bus.mem_address[1:0] != 2'b00) && ((bus.mem_wmask & low_mask) != 4'b0000))
      viol = 1'b1;
    if ((state_q == BUSY) &&
        ({bus.mem_address, bus.mem_read, bus.mem_write, bus.mem_wmask, bus.mem_wdata} !=
         {addr_q, rd_q, wr_q, wmask_q, wdata_q}))
      viol = 1'b1;
    err_d = err_q | viol;
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && viol) $error("dmem_responder: protocol violation, state %0d", state_q);
  end
`endif

  assign bus.mem_err = err_q;
`else
  assign bus.mem_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: LATENCY=2 instance with random traffic, LATENCY=1 back-to-back.
module tb_dmem_responder;
  localparam int DEPTH = 1024;
  localparam int LAT0  = 2;
  localparam int LAT1  = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_if bus0 ();
  dmem_if bus1 ();
  logic [1:0] dbg0, dbg1;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .dbg_state(dbg0)
  );
  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .dbg_state(dbg1)
  );

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  int          resp1_cnt = 0;
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  int          cyc_q0[$];
  int          cyc_q1[$];
  logic [31:0] mdl [2][DEPTH];
  logic [31:0] words [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (bus0.mem_resp === 1'b1) begin
        if (exp_q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL resp0_unexpected: got resp=1 expected none (cycle %0d)", cyc);
        end else begin
          check("rdata0", bus0.mem_rdata, exp_q0.pop_front());
          check("latency0", cyc, cyc_q0.pop_front());
        end
      end else check("idle_rdata0", bus0.mem_rdata, 32'h0);
      if (bus1.mem_resp === 1'b1) begin
        resp1_cnt++;
        if (exp_q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL resp1_unexpected: got resp=1 expected none (cycle %0d)", cyc);
        end else begin
          check("rdata1", bus1.mem_rdata, exp_q1.pop_front());
          check("latency1", cyc, cyc_q1.pop_front());
        end
      end else check("idle_rdata1", bus1.mem_rdata, 32'h0);
    end
  end

  // ---------------- reference model ----------------
  task automatic model(input int sel, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [3:0] m, input logic [31:0] d, output logic [31:0] e);
    int idx;
    idx = int'(a[31:2]) % DEPTH;
    e = (rd && !wr) ? mdl[sel][idx] : 32'h0;
    if (wr) begin
      for (int b = 0; b < 4; b++) if (m[b]) mdl[sel][idx][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input int sel, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [3:0] m, input logic [31:0] d);
    if (sel == 0) begin
      bus0.mem_read = rd; bus0.mem_write = wr; bus0.mem_address = a;
      bus0.mem_wmask = m; bus0.mem_wdata = d;
    end else begin
      bus1.mem_read = rd; bus1.mem_write = wr; bus1.mem_address = a;
      bus1.mem_wmask = m; bus1.mem_wdata = d;
    end
  endtask

  // Issues one request in the next cycle, holds it until resp (optionally scrambling it
  // after acceptance), and drops it in the resp cycle.
  task automatic req(input int sel, input logic rd, input logic wr, input logic [31:0] a,
                     input logic [3:0] m, input logic [31:0] d, input bit wob);
    logic [31:0] e;
    bit          seen;
    seen = 0;
    @(negedge clk);
    model(sel, rd, wr, a, m, d, e);
    if (sel == 0) begin exp_q0.push_back(e); cyc_q0.push_back(cyc + LAT0); end
    else          begin exp_q1.push_back(e); cyc_q1.push_back(cyc + LAT1); end
    drive(sel, rd, wr, a, m, d);
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if ((sel == 0) ? bus0.mem_resp : bus1.mem_resp) seen = 1;
      else if (wob && k == 0)
        drive(sel, 1'b0, 1'b0, $urandom & 32'hFFFF_FFFC, 4'($urandom), $urandom);
    end
    drive(sel, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    if (!seen) begin
      checks++; errors++;
      $display("FAIL resp_timeout: got no resp expected one (bus %0d, cycle %0d)", sel, cyc);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] a;
    int          op;
    bit          rd, wr, wob;

    words[0] = 32'h000; words[1] = 32'h040; words[2] = 32'h044; words[3] = 32'h080;
    words[4] = 32'h100; words[5] = 32'h204; words[6] = 32'h3F8; words[7] = 32'hFFC;
    drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_resp", bus0.mem_resp, 32'h0);
    check("reset_rdata", bus0.mem_rdata, 32'h0);
    check("reset_err", bus0.mem_err, 32'h0);
    check("reset_resp1", bus1.mem_resp, 32'h0);
    rst = 1'b0;

    foreach (words[i]) req(0, 1'b0, 1'b1, words[i], 4'hF, $urandom, 1'b0);

    // full write then read-back
    req(0, 1'b0, 1'b1, 32'h40, 4'hF, 32'hDEADBEEF, 1'b0);
    req(0, 1'b1, 1'b0, 32'h40, 4'h0, 32'h0, 1'b0);
    // single-lane write
    req(0, 1'b0, 1'b1, 32'h40, 4'b0010, 32'h0000AA00, 1'b0);
    req(0, 1'b1, 1'b0, 32'h40, 4'h0, 32'h0, 1'b0);
    // empty mask modifies nothing
    req(0, 1'b0, 1'b1, 32'h40, 4'b0000, 32'h55555555, 1'b0);
    req(0, 1'b1, 1'b0, 32'h40, 4'h0, 32'h0, 1'b0);
    // wrap: 0x1000 aliases word 0
    req(0, 1'b0, 1'b1, 32'h1000, 4'hF, 32'h00000011, 1'b0);
    req(0, 1'b1, 1'b0, 32'h0000, 4'h0, 32'h0, 1'b0);

    // reset one cycle into a write: no resp, no array update
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 32'h80, 4'hF, 32'h12345678);
    @(negedge clk);
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    check("rst_mid_resp", bus0.mem_resp, 32'h0);
    check("rst_mid_rdata", bus0.mem_rdata, 32'h0);
    check("rst_mid_err", bus0.mem_err, 32'h0);
    rst = 1'b0;
    req(0, 1'b1, 1'b0, 32'h80, 4'h0, 32'h0, 1'b0);

    // LATENCY=1 instance: one write then five back-to-back reads
    req(1, 1'b0, 1'b1, 32'h40, 4'hF, $urandom, 1'b0);
    for (int i = 0; i < 5; i++) req(1, 1'b1, 1'b0, 32'h40, 4'h0, 32'h0, 1'b0);
    @(negedge clk);
    check("resp1_count", resp1_cnt, 32'd6);

`ifdef DMEM_RESP_CHECK_EN
    // address changed while BUSY: error latched, transaction completes on the original word
    req(0, 1'b1, 1'b0, 32'h40, 4'h0, 32'h0, 1'b1);
    check("err_set", bus0.mem_err, 32'h1);
    repeat (5) @(negedge clk);
    check("err_sticky", bus0.mem_err, 32'h1);
`endif

    for (int n = 0; n < 200; n++) begin
      op = $urandom_range(0, 9);
      rd = (op < 5) || (op == 9);
      wr = (op >= 5);
      a  = words[$urandom_range(0, 7)] + ($urandom_range(0, 3) << 12);
      wob = 1'b0;
`ifndef DMEM_RESP_CHECK_EN
      a   = a | 32'($urandom_range(0, 3));
      wob = ($urandom_range(0, 7) == 0);
`else
      if (rd && wr) rd = 1'b0;
`endif
      req(0, rd, wr, a, 4'($urandom), $urandom, wob);
    end

    for (int k = 0; k < 50 && (exp_q0.size() != 0 || exp_q1.size() != 0); k++) @(negedge clk);
    check("drain0", exp_q0.size(), 32'd0);
    check("drain1", exp_q1.size(), 32'd0);
`ifndef DMEM_RESP_CHECK_EN
    check("err_tied_low", bus0.mem_err, 32'h0);
    check("err_tied_low1", bus1.mem_err, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end
endmodule
